sym_tx_jdl25175: RTL and testbench

Two-bit symbol transmitter. It accepts a parallel data word through a load/ready handshake and emits it as a framed stream of 2-bit symbols: a start symbol, then the data MSB-first, then an optional parity symbol. It is the source that drives the 2-bit `in` port of the one-hot symbol-recognizer FSMs, and serves as their stimulus generator in system benches.

---
 rtl/sym_tx_jdl25175.sv | 106 ++++++++++
 tb/tb_sym_tx_jdl25175.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sym_tx_jdl25175.sv
// Framed 2-bit symbol transmitter: start symbol, data MSB-first, optional parity.
// Optional parity tail symbol is compiled in with `define SYMTX_PARITY_EN.
module sym_tx_jdl25175 #(
  parameter int NSYM = 4
) (
  input  logic              clock,
  input  logic              init,
  input  logic              load,
  input  logic [2*NSYM-1:0] data,
  output logic              ready,
  output logic [1:0]        sym,
  output logic              frame,
  output logic [3:0]        state
);

  localparam int W  = 2 * NSYM;
  localparam int CW = $clog2(NSYM) + 1;
  localparam logic [CW-1:0] LAST = CW'(NSYM - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    DATA  = 4'b0100,
    TAIL  = 4'b1000
  } st_t;

  st_t           st_q, st_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef SYMTX_PARITY_EN
  logic          par_q, par_d;
`endif

  always_ff @(posedge clock or negedge init) begin
    if (!init) begin
      st_q  <= IDLE;
      sh_q  <= '0;
      cnt_q <= '0;
`ifdef SYMTX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      st_q  <= st_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
`ifdef SYMTX_PARITY_EN
      par_q <= par_d;
`endif
    end
  end

  always_comb begin
    st_d  = st_q;
    sh_d  = sh_q;
    cnt_d = cnt_q;
`ifdef SYMTX_PARITY_EN
    par_d = par_q;
`endif
    sym   = 2'b00;
    ready = 1'b0;
    frame = 1'b0;
    case (st_q)
      IDLE: begin
        ready = 1'b1;
        if (load) begin
          sh_d  = data;
          cnt_d = '0;
`ifdef SYMTX_PARITY_EN
          par_d = ^data;
`endif
          st_d  = START;
        end
      end
      START: begin
        sym   = 2'b11;
        frame = 1'b1;
        st_d  = DATA;
      end
      DATA: begin
        sym   = sh_q[W-1 -: 2];
        frame = 1'b1;
        sh_d  = sh_q << 2;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
`ifdef SYMTX_PARITY_EN
          st_d = TAIL;
`else
          st_d = IDLE;
`endif
        end
      end
`ifdef SYMTX_PARITY_EN
      TAIL: begin
        sym   = {~par_q, par_q};
        frame = 1'b1;
        st_d  = IDLE;
      end
`endif
      // illegal encodings recover to IDLE with sym=00
      default: st_d = IDLE;
    endcase
  end

  assign state = st_q;

endmodule

// File: tb/tb_sym_tx_jdl25175.sv
// Scoreboard bench for sym_tx_jdl25175: expected frames queued at acceptance.
// Follows SYMTX_PARITY_EN the same way as the design build.
module tb_sym_tx_jdl25175;

  localparam int NSYM = 4;
  localparam int W    = 2 * NSYM;

  logic         clock = 1'b0;
  logic         init  = 1'b0;
  logic         load  = 1'b0;
  logic [W-1:0] data  = '0;
  logic         ready;
  logic [1:0]   sym;
  logic         frame;
  logic [3:0]   state;

  typedef struct {
    logic [1:0] s;
    logic [3:0] st;
  } exp_t;

  exp_t q[$];
  int   ncmp = 0;
  int   nbad = 0;

  sym_tx_jdl25175 #(.NSYM(NSYM)) dut (
    .clock(clock),
    .init (init),
    .load (load),
    .data (data),
    .ready(ready),
    .sym  (sym),
    .frame(frame),
    .state(state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] d);
    exp_t e;
    e.s = 2'b11; e.st = 4'b0010;
    q.push_back(e);
    for (int i = 0; i < NSYM; i++) begin
      e.s  = {d[W-1-2*i], d[W-2-2*i]};
      e.st = 4'b0100;
      q.push_back(e);
    end
`ifdef SYMTX_PARITY_EN
    e.s  = {~(^d), ^d};
    e.st = 4'b1000;
    q.push_back(e);
`endif
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!init || q.size() == 0) begin
      chk("idle_sym",   {30'd0, sym},   32'd0);
      chk("idle_state", {28'd0, state}, 32'd1);
      chk("idle_ready", {31'd0, ready}, 32'd1);
      chk("idle_frame", {31'd0, frame}, 32'd0);
      if (init && load) push_frame(data);
    end else begin
      e = q.pop_front();
      chk("frm_sym",   {30'd0, sym},   {30'd0, e.s});
      chk("frm_state", {28'd0, state}, {28'd0, e.st});
      chk("frm_ready", {31'd0, ready}, 32'd0);
      chk("frm_frame", {31'd0, frame}, 32'd1);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    tick(2);
    chk("rst_state", {28'd0, state}, 32'd1);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    init = 1'b1;
    tick(2);

    // single frame B4
    data = 8'hB4; load = 1'b1;
    tick(1);
    load = 1'b0; data = 8'h00;
    tick(10);

    // odd parity
    data = 8'h01; load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(10);

    // busy load ignored, then held into IDLE
    data = 8'hFF; load = 1'b1;
    tick(2);
    data = 8'h00;
    tick(6);
    load = 1'b0;
    tick(20);

    // reset mid-DATA, then immediate reload
    data = 8'hA5; load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(2);
    init = 1'b0;
    #1;
    chk("mid_rst_state", {28'd0, state}, 32'd1);
    chk("mid_rst_sym",   {30'd0, sym},   32'd0);
    chk("mid_rst_ready", {31'd0, ready}, 32'd1);
    chk("mid_rst_frame", {31'd0, frame}, 32'd0);
    q.delete();
    tick(2);
    init = 1'b1; data = 8'h3C; load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(10);

    // continuous load with changing data
    load = 1'b1;
    for (int i = 0; i < 30; i++) begin
      data = W'($urandom);
      tick(1);
    end
    load = 1'b0;
    tick(12);

    chk("drain", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
